// File: rtl/four_output_demux_pkg.sv
// four_output_demux_pkg: shared definitions for the four-way stream mux/demux
// family.
//   sel_e      - select encoding for destination/source slots
//   slot_st_e  - two-state per-slot control (EMPTY/FULL)
//   NUM_SLOTS  - number of slots
package four_output_demux_pkg;

   localparam int NUM_SLOTS = 4;

   typedef enum logic [1:0] {
      SEL_A = 2'd0,
      SEL_B = 2'd1,
      SEL_C = 2'd2,
      SEL_D = 2'd3
   } sel_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_st_e;

endpackage

// File: rtl/four_output_demux_if.sv
// four_output_demux_if: producer-side and consumer-side handshake bundle
// for the four-output demux.
//   a, sel, in_valid, in_ready   - producer handshake
//   z_a..z_d, z_valid, z_ready   - per-slot consumer handshake
//   cnt_flat                     - per-slot drain counters (DEMUX_STATS_EN only)
// Modports: slave = the demux, master = producer/consumer environment.
// Optional feature macro: DEMUX_STATS_EN.
interface four_output_demux_if #(
   parameter int INPUT_LENGTH = 32,
   parameter int CNT_WIDTH    = 16
);
   logic [INPUT_LENGTH-1:0] a;
   logic [1:0]              sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [INPUT_LENGTH-1:0] z_a, z_b, z_c, z_d;
   logic [3:0]              z_valid;
   logic [3:0]              z_ready;
`ifdef DEMUX_STATS_EN
   logic [4*CNT_WIDTH-1:0]  cnt_flat;

   modport slave  (input  a, sel, in_valid, z_ready,
                   output in_ready, z_a, z_b, z_c, z_d, z_valid, cnt_flat);
   modport master (output a, sel, in_valid, z_ready,
                   input  in_ready, z_a, z_b, z_c, z_d, z_valid, cnt_flat);
`else
   modport slave  (input  a, sel, in_valid, z_ready,
                   output in_ready, z_a, z_b, z_c, z_d, z_valid);
   modport master (output a, sel, in_valid, z_ready,
                   input  in_ready, z_a, z_b, z_c, z_d, z_valid);
`endif
endinterface

// File: rtl/four_output_demux_slot.sv
// demux_slot: one-entry holding register for one demux destination.
//   clk, rst_n - clock, synchronous active-low reset
//   i_fill     - write i_data into the slot this edge (already qualified)
//   i_data     - word to store
//   i_ready    - consumer takes the slot this edge
//   o_valid    - slot full
//   o_data     - held word (keeps last value after draining)
//   o_cnt      - drain counter, wraps (DEMUX_STATS_EN only)
// Optional feature macro: DEMUX_STATS_EN.
module demux_slot
   import four_output_demux_pkg::*;
#(
   parameter int INPUT_LENGTH = 32,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_fill,
   input  logic [INPUT_LENGTH-1:0] i_data,
   input  logic                    i_ready,
`ifdef DEMUX_STATS_EN
   output logic [CNT_WIDTH-1:0]    o_cnt,
`endif
   output logic                    o_valid,
   output logic [INPUT_LENGTH-1:0] o_data
);

   slot_st_e                r_state;
   slot_st_e                w_next;
   logic [INPUT_LENGTH-1:0] r_data;
   logic                    w_drain;

   assign w_drain = (r_state == ST_FULL) & i_ready;

   // Fill wins over drain: a same-edge drain+fill keeps the slot full.
   always_comb begin
      w_next = r_state;
      if (i_fill)       w_next = ST_FULL;
      else if (w_drain) w_next = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (i_fill) r_data <= i_data;
      end
   end

   assign o_valid = (r_state == ST_FULL);
   assign o_data  = r_data;

`ifdef DEMUX_STATS_EN
   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)       r_cnt <= '0;
      else if (w_drain) r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/four_output_demux.sv
// four_output_demux: registered 1-to-4 stream demultiplexer.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - four_output_demux_if.slave: a/sel/in_valid/in_ready from the
//                producer, z_a..z_d/z_valid/z_ready per consumer slot,
//                cnt_flat per-slot drain counts when enabled.
// in_ready depends only on the selected slot, so a stalled slot never blocks
// the other three. Optional feature macro: DEMUX_STATS_EN.
module four_output_demux
   import four_output_demux_pkg::*;
#(
   parameter int INPUT_LENGTH = 32,
   parameter int CNT_WIDTH    = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   four_output_demux_if.slave  bus
);

   logic [NUM_SLOTS-1:0]                   w_valid;
   logic [NUM_SLOTS-1:0]                   w_fill;
   logic [NUM_SLOTS-1:0][INPUT_LENGTH-1:0] w_data;
   logic                                   w_accept;

   assign bus.in_ready = ~w_valid[bus.sel] | bus.z_ready[bus.sel];
   assign w_accept     = bus.in_valid & bus.in_ready;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      assign w_fill[i] = w_accept & (bus.sel == 2'(i));

      demux_slot #(
         .INPUT_LENGTH (INPUT_LENGTH),
         .CNT_WIDTH    (CNT_WIDTH)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_fill  (w_fill[i]),
         .i_data  (bus.a),
         .i_ready (bus.z_ready[i]),
`ifdef DEMUX_STATS_EN
         .o_cnt   (bus.cnt_flat[i*CNT_WIDTH +: CNT_WIDTH]),
`endif
         .o_valid (w_valid[i]),
         .o_data  (w_data[i])
      );
   end

   assign bus.z_valid = w_valid;
   assign bus.z_a     = w_data[SEL_A];
   assign bus.z_b     = w_data[SEL_B];
   assign bus.z_c     = w_data[SEL_C];
   assign bus.z_d     = w_data[SEL_D];

endmodule

// File: tb/tb_four_output_demux.sv
module tb_four_output_demux;
   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   four_output_demux_if #(.INPUT_LENGTH(W), .CNT_WIDTH(CW)) bus ();

   four_output_demux #(.INPUT_LENGTH(W), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: each destination is a one-word mailbox.
   logic          mv    [4];
   logic [W-1:0]  md    [4];
   logic [CW-1:0] mc    [4];
   bit            known;
   int            n_checks;
   int            n_errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [3:0]      ev;
      logic [4*CW-1:0] ec;
      for (int i = 0; i < 4; i++) begin
         ev[i] = mv[i];
         ec[i*CW +: CW] = mc[i];
      end
      chk("z_valid", 64'(bus.z_valid), 64'(ev));
      chk("z_a", 64'(bus.z_a), 64'(md[0]));
      chk("z_b", 64'(bus.z_b), 64'(md[1]));
      chk("z_c", 64'(bus.z_c), 64'(md[2]));
      chk("z_d", 64'(bus.z_d), 64'(md[3]));
`ifdef DEMUX_STATS_EN
      chk("cnt_flat", 64'(bus.cnt_flat), 64'(ec));
`endif
   endtask

   // One clock: drive at negedge, check in_ready, advance the model across the
   // edge, then check registered outputs just after it.
   task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] zr, input logic rst);
      logic rdy;
      @(negedge clk);
      bus.in_valid = v; bus.sel = s; bus.a = d; bus.z_ready = zr; rst_n = rst;
      #1;
      rdy = !mv[s] || zr[s];
      if (known) chk("in_ready", 64'(bus.in_ready), 64'(rdy));
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = '0; mc[i] = '0; end
         known = 1;
      end else if (known) begin
         for (int i = 0; i < 4; i++)
            if (mv[i] && zr[i]) begin mv[i] = 0; mc[i] = mc[i] + 1'b1; end
         if (v && rdy) begin mv[s] = 1; md[s] = d; end
      end
      #1;
      if (known) check_outputs();
   endtask

   initial begin
      n_checks = 0; n_errors = 0; known = 0;
      for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = '0; mc[i] = '0; end
      bus.in_valid = 0; bus.sel = 0; bus.a = 0; bus.z_ready = 0; rst_n = 0;

      // Reset held with in_valid high: nothing is accepted.
      step(1, 2'd0, 8'hff, 4'b0000, 0);
      step(1, 2'd0, 8'hff, 4'b0000, 0);
      @(negedge clk); rst_n = 1; bus.in_valid = 0; #1;
      chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

      // Routing to each slot with consumers always ready.
      step(1, 2'd0, 8'h03, 4'b1111, 1);
      chk("route_a", 64'(bus.z_a), 64'h03);
      step(1, 2'd1, 8'hff, 4'b1111, 1);
      step(1, 2'd2, 8'h0f, 4'b1111, 1);
      step(1, 2'd3, 8'hee, 4'b1111, 1);
      chk("route_d", 64'(bus.z_d), 64'hee);
      step(0, 2'd0, 8'h00, 4'b1111, 1);

      // Backpressure on slot 2, then same-edge drain and refill.
      step(1, 2'd2, 8'h11, 4'b0000, 1);
      step(1, 2'd2, 8'h22, 4'b0000, 1);
      chk("bp_hold", 64'(bus.z_c), 64'h11);
      step(1, 2'd2, 8'h22, 4'b0100, 1);
      chk("bp_refill", 64'({bus.z_valid[2], bus.z_c}), 64'h122);
      step(0, 2'd2, 8'h00, 4'b0100, 1);

      // Independence: slot 0 stalled full, slot 1 still accepts.
      step(1, 2'd0, 8'h55, 4'b0000, 1);
      step(1, 2'd1, 8'h0f, 4'b0000, 1);
      chk("indep_b", 64'(bus.z_b), 64'h0f);
      chk("indep_a", 64'(bus.z_a), 64'h55);
      step(0, 2'd0, 8'h00, 4'b1111, 1);

      // Streaming into slot 3 back-to-back.
      for (int k = 0; k < 10; k++) begin
         step(1, 2'd3, 8'(k), 4'b1000, 1);
         chk("stream_d", 64'(bus.z_d), 64'(k));
      end
      step(0, 2'd0, 8'h00, 4'b1111, 1);

`ifdef DEMUX_STATS_EN
      // 17 drains of slot 1 wrap a 4-bit counter to 1.
      step(0, 2'd0, 8'h00, 4'b0000, 0);
      for (int k = 0; k < 17; k++) step(1, 2'd1, 8'(k + 8'h40), 4'b0010, 1);
      step(0, 2'd0, 8'h00, 4'b0010, 1);
      chk("cnt_wrap", 64'(bus.cnt_flat), 64'h0010);
      step(1, 2'd1, 8'h77, 4'b0010, 0);
      chk("cnt_reset", 64'(bus.cnt_flat), 64'h0);
`endif

      // Randomised traffic with occasional reset.
      for (int k = 0; k < 400; k++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
              4'($urandom), $urandom_range(0, 60) != 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
